oflow_score_board: RTL and testbench
====================================

OFLOW_SCORE_BOARD -- requirements
Module: oflow_score_board

Interface
REQ-001 SHALL expose parameter PE_NUM, default 8: PE entries per set (row).
REQ-002 SHALL expose parameter ROW_LEN, default 5: row-index width; the board holds 2^ROW_LEN rows.
REQ-003 SHALL expose parameter ID_LEN, default 12: object ID width.
REQ-004 SHALL expose parameter SCORE_LEN, default 16: score width.
REQ-005 SHALL have port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-006 SHALL have port reset_N, input, 1 bit: asynchronous, active-low reset.
REQ-007 SHALL have port start_score_board, input, 1 bit: single-cycle request to write one set.
REQ-008 SHALL have port done_score_board, output, 1 bit: single-cycle completion pulse.
REQ-009 SHALL have port frame_num, input, `TOTAL_FRAME_NUM_WIDTH bits: zero means first frame.
REQ-010 SHALL have port row_sel_by_set, input, ROW_LEN bits: target row for the set.
REQ-011 SHALL have port id_first_frame, input, ID_LEN bits: base ID for PE 0 in the first frame.
REQ-012 SHALL have port id_in, input, PE_NUM*ID_LEN bits: matched ID per PE (frame_num>0).
REQ-013 SHALL have port score_in, input, PE_NUM*SCORE_LEN bits: match score per PE.
REQ-014 SHALL have port valid_pe, input, PE_NUM bits: per-PE valid mask.
REQ-015 SHALL have port clear_board, input, 1 bit: clears all valid bits.
REQ-016 SHALL have port busy, output, 1 bit: high in WRITE and DONE.
REQ-017 SHALL have ports rd_row (ROW_LEN) and rd_pe ($clog2(PE_NUM)), inputs: read address.
REQ-018 SHALL have ports rd_id (ID_LEN), rd_score (SCORE_LEN) and rd_valid (1), outputs: registered read data.

Function
REQ-019 FSM states SHALL be IDLE, WRITE and DONE.
REQ-020 In IDLE, start_score_board=1 SHALL latch row_sel_by_set, id_first_frame, frame_num==0, id_in, score_in and valid_pe, clear pe_cnt to 0 and go to WRITE.
REQ-021 WRITE SHALL write one entry per cycle at [row][pe_cnt], pe_cnt = 0..PE_NUM-1, and go to DONE after pe_cnt = PE_NUM-1.
REQ-022 In the first frame, each entry SHALL take id = id_first_frame + pe_cnt (modulo 2^ID_LEN) and score = 0.
REQ-023 Otherwise, each entry SHALL take id = id_in[pe_cnt] and score = score_in[pe_cnt].
REQ-024 The entry valid bit SHALL equal valid_pe[pe_cnt]; when it is 0, id and score SHALL still be written.
REQ-025 DONE SHALL assert done_score_board for exactly one cycle and return to IDLE.
REQ-026 Latency: for start sampled at edge t, writes SHALL occur at edges t+1..t+PE_NUM and done SHALL be high in cycle t+PE_NUM+1.
REQ-027 start_score_board while busy SHALL be ignored, with no queuing and no effect on the current set.
REQ-028 Inputs are latched at start; input changes during WRITE SHALL NOT affect written data.
REQ-029 clear_board in IDLE SHALL zero every valid bit in one cycle.
REQ-030 clear_board while busy SHALL be ignored.
REQ-031 If clear_board and start_score_board are both high in IDLE, clear SHALL apply first and the set SHALL then be written normally.
REQ-032 Read data SHALL have 1-cycle latency.
REQ-033 A read of the entry being written in the same cycle SHALL return the old contents (read-before-write).
REQ-034 All row_sel_by_set values SHALL be legal; there is no out-of-range case.

Reset
REQ-035 reset_N=0 SHALL immediately set the state to IDLE and clear pe_cnt, done_score_board, busy, rd_valid, all valid bits and all latched inputs.
REQ-036 Reset asserted mid-WRITE SHALL abandon the set with no done pulse.
REQ-037 Stored id and score contents need not reset; rd_id and rd_score SHALL reset to 0.

Structure
REQ-038 PE_NUM, ROW_LEN, ID_LEN and SCORE_LEN defaults and the state enum SHALL live in the shared oflow_core package/define file.
REQ-039 Storage SHALL be one sub-module, oflow_score_board_mem: a 2^ROW_LEN x PE_NUM array with 1 write port, 1 read port and a valid-clear.

Verification
REQ-040 Reset, then start with frame_num=0, row=3, id_first_frame=17, valid_pe=8'hFF -> done in cycle t+9; row 3 reads IDs 17..24, all scores 0, all valid.
REQ-041 frame_num=5, row=31, id_in[i]=100+i, score_in[i]=10*i, valid_pe=8'hA5 -> PE1 reads id 101, score 10, invalid; PE2 reads id 102, score 20, valid.
REQ-042 Second start at t+3 while busy -> ignored; exactly one done pulse at t+9.
REQ-043 Read [3][2] while that entry is written -> old value; reading again next cycle -> new value.
REQ-044 reset_N low at t+4 during WRITE -> no done pulse, all rd_valid=0; a fresh start then completes normally.
REQ-045 clear_board and start together in IDLE (row=0) -> only row 0 entries valid afterwards.

Source files
------------

// File: rtl/oflow_core_pkg.sv
// Shared oflow core definitions: score-board parameter defaults, frame-number
// width and the write-sequencer state encoding.
package oflow_core_pkg;

  localparam int PE_NUM_DEF            = 8;
  localparam int ROW_LEN_DEF           = 5;
  localparam int ID_LEN_DEF            = 12;
  localparam int SCORE_LEN_DEF         = 16;
  localparam int TOTAL_FRAME_NUM_WIDTH = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    DONE  = 2'd2
  } sb_state_e;

  // Counter width that stays legal when only one PE exists.
  function automatic int cnt_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/oflow_score_board_if.sv
// Score-board request/read bus; master drives sets and read addresses, slave
// (the board) returns status and registered read data.
interface oflow_score_board_if import oflow_core_pkg::*; #(
  parameter int PE_NUM    = PE_NUM_DEF,
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int ID_LEN    = ID_LEN_DEF,
  parameter int SCORE_LEN = SCORE_LEN_DEF,
  localparam int PE_W     = cnt_w(PE_NUM)
) ();

  logic                             start_score_board;
  logic                             done_score_board;
  logic [TOTAL_FRAME_NUM_WIDTH-1:0] frame_num;
  logic [ROW_LEN-1:0]               row_sel_by_set;
  logic [ID_LEN-1:0]                id_first_frame;
  logic [PE_NUM*ID_LEN-1:0]         id_in;
  logic [PE_NUM*SCORE_LEN-1:0]      score_in;
  logic [PE_NUM-1:0]                valid_pe;
  logic                             clear_board;
  logic                             busy;
  logic [ROW_LEN-1:0]               rd_row;
  logic [PE_W-1:0]                  rd_pe;
  logic [ID_LEN-1:0]                rd_id;
  logic [SCORE_LEN-1:0]             rd_score;
  logic                             rd_valid;

  modport master (
    output start_score_board, frame_num, row_sel_by_set, id_first_frame,
           id_in, score_in, valid_pe, clear_board, rd_row, rd_pe,
    input  done_score_board, busy, rd_id, rd_score, rd_valid
  );

  modport slave (
    input  start_score_board, frame_num, row_sel_by_set, id_first_frame,
           id_in, score_in, valid_pe, clear_board, rd_row, rd_pe,
    output done_score_board, busy, rd_id, rd_score, rd_valid
  );

endinterface

// File: rtl/oflow_score_board_mem.sv
// Score-board storage: rows x PE entries of {id, score, valid}, one write
// port, one registered read port and a single-cycle clear of all valid bits.
module oflow_score_board_mem import oflow_core_pkg::*; #(
  parameter int PE_NUM    = PE_NUM_DEF,
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int ID_LEN    = ID_LEN_DEF,
  parameter int SCORE_LEN = SCORE_LEN_DEF,
  localparam int PE_W     = cnt_w(PE_NUM)
) (
  input  logic                 clk,
  input  logic                 reset_N,
  input  logic                 we_i,
  input  logic [ROW_LEN-1:0]   wr_row_i,
  input  logic [PE_W-1:0]      wr_pe_i,
  input  logic [ID_LEN-1:0]    wr_id_i,
  input  logic [SCORE_LEN-1:0] wr_score_i,
  input  logic                 wr_valid_i,
  input  logic                 clr_i,
  input  logic [ROW_LEN-1:0]   rd_row_i,
  input  logic [PE_W-1:0]      rd_pe_i,
  output logic [ID_LEN-1:0]    rd_id_o,
  output logic [SCORE_LEN-1:0] rd_score_o,
  output logic                 rd_valid_o
);

  localparam int ROWS = 1 << ROW_LEN;

  logic [ID_LEN-1:0]            id_mem    [ROWS][PE_NUM];
  logic [SCORE_LEN-1:0]         score_mem [ROWS][PE_NUM];
  logic [ROWS-1:0][PE_NUM-1:0]  valid_q;
  logic [ID_LEN-1:0]            rd_id_q;
  logic [SCORE_LEN-1:0]         rd_score_q;
  logic                         rd_valid_q;

  // NOTE: payload arrays have no reset so they can map onto plain RAM; only
  // the valid bits need a defined power-up value.
  always_ff @(posedge clk) begin
    if (we_i) begin
      id_mem[wr_row_i][wr_pe_i]    <= wr_id_i;
      score_mem[wr_row_i][wr_pe_i] <= wr_score_i;
    end
  end

  // A write in the same cycle as a clear still lands after the clear.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      valid_q <= '0;
    end else begin
      if (clr_i) valid_q <= '0;
      if (we_i)  valid_q[wr_row_i][wr_pe_i] <= wr_valid_i;
    end
  end

  // NOTE: non-blocking assignment samples pre-edge contents, so a read of the
  // entry being written returns the old value (read-before-write).
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      rd_id_q    <= '0;
      rd_score_q <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      rd_id_q    <= id_mem[rd_row_i][rd_pe_i];
      rd_score_q <= score_mem[rd_row_i][rd_pe_i];
      rd_valid_q <= valid_q[rd_row_i][rd_pe_i];
    end
  end

  assign rd_id_o    = rd_id_q;
  assign rd_score_o = rd_score_q;
  assign rd_valid_o = rd_valid_q;

endmodule

// File: rtl/oflow_score_board.sv
// Optical-flow score board: latches one set of PE results on start and writes
// it into the selected row one PE per cycle, then pulses done.
module oflow_score_board import oflow_core_pkg::*; #(
  parameter int PE_NUM    = PE_NUM_DEF,
  parameter int ROW_LEN   = ROW_LEN_DEF,
  parameter int ID_LEN    = ID_LEN_DEF,
  parameter int SCORE_LEN = SCORE_LEN_DEF,
  localparam int PE_W     = cnt_w(PE_NUM)
) (
  input logic               clk,
  input logic               reset_N,
  oflow_score_board_if.slave sb
);

  sb_state_e                   state_q, state_d;
  logic [PE_W-1:0]             pe_cnt_q, pe_cnt_d;
  logic [ROW_LEN-1:0]          row_q;
  logic [ID_LEN-1:0]           base_q;
  logic                        first_q;
  logic [PE_NUM*ID_LEN-1:0]    ids_q;
  logic [PE_NUM*SCORE_LEN-1:0] scores_q;
  logic [PE_NUM-1:0]           vmask_q;

  logic                        start_ok;
  logic                        last_pe;
  logic [ID_LEN-1:0]           wr_id;
  logic [SCORE_LEN-1:0]        wr_score;

  assign start_ok = (state_q == IDLE) && sb.start_score_board;
  assign last_pe  = (pe_cnt_q == PE_W'(PE_NUM - 1));

  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      state_q  <= IDLE;
      pe_cnt_q <= '0;
    end else begin
      state_q  <= state_d;
      pe_cnt_q <= pe_cnt_d;
    end
  end

  // Set inputs are captured only on an accepted start, so later input
  // activity cannot disturb a set already in flight.
  always_ff @(posedge clk or negedge reset_N) begin
    if (!reset_N) begin
      row_q    <= '0;
      base_q   <= '0;
      first_q  <= 1'b0;
      ids_q    <= '0;
      scores_q <= '0;
      vmask_q  <= '0;
    end else if (start_ok) begin
      row_q    <= sb.row_sel_by_set;
      base_q   <= sb.id_first_frame;
      first_q  <= (sb.frame_num == '0);
      ids_q    <= sb.id_in;
      scores_q <= sb.score_in;
      vmask_q  <= sb.valid_pe;
    end
  end

  // NOTE: every always_comb output gets a default first, so no path can
  // leave a variable unassigned and infer a latch.
  always_comb begin
    state_d  = state_q;
    pe_cnt_d = pe_cnt_q;
    unique case (state_q)
      IDLE: begin
        if (sb.start_score_board) begin
          state_d  = WRITE;
          pe_cnt_d = '0;
        end
      end
      WRITE: begin
        if (last_pe) state_d  = DONE;
        else         pe_cnt_d = pe_cnt_q + 1'b1;
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  assign wr_id    = first_q ? base_q + ID_LEN'(pe_cnt_q)
                            : ids_q[int'(pe_cnt_q)*ID_LEN +: ID_LEN];
  assign wr_score = first_q ? '0 : scores_q[int'(pe_cnt_q)*SCORE_LEN +: SCORE_LEN];

  assign sb.done_score_board = (state_q == DONE);
  assign sb.busy             = (state_q != IDLE);

  oflow_score_board_mem #(
    .PE_NUM    (PE_NUM),
    .ROW_LEN   (ROW_LEN),
    .ID_LEN    (ID_LEN),
    .SCORE_LEN (SCORE_LEN)
  ) u_mem (
    .clk        (clk),
    .reset_N    (reset_N),
    .we_i       (state_q == WRITE),
    .wr_row_i   (row_q),
    .wr_pe_i    (pe_cnt_q),
    .wr_id_i    (wr_id),
    .wr_score_i (wr_score),
    .wr_valid_i (vmask_q[pe_cnt_q]),
    .clr_i      ((state_q == IDLE) && sb.clear_board),
    .rd_row_i   (sb.rd_row),
    .rd_pe_i    (sb.rd_pe),
    .rd_id_o    (sb.rd_id),
    .rd_score_o (sb.rd_score),
    .rd_valid_o (sb.rd_valid)
  );

endmodule

// File: tb/tb_oflow_score_board.sv
// Scoreboard bench for oflow_score_board: directed scenarios plus random sets
// checked against an array model of the board and the set/done timing rules.
module tb_oflow_score_board;
  import oflow_core_pkg::*;

  localparam int PE   = 8;
  localparam int RL   = 5;
  localparam int IL   = 12;
  localparam int SL   = 16;
  localparam int ROWS = 1 << RL;
  localparam int PW   = 3;
  localparam int FW   = TOTAL_FRAME_NUM_WIDTH;

  logic clk = 1'b0;
  logic reset_N = 1'b0;
  always #5 clk = ~clk;

  oflow_score_board_if #(.PE_NUM(PE), .ROW_LEN(RL), .ID_LEN(IL), .SCORE_LEN(SL)) sb_if ();

  oflow_score_board #(.PE_NUM(PE), .ROW_LEN(RL), .ID_LEN(IL), .SCORE_LEN(SL)) dut (
    .clk     (clk),
    .reset_N (reset_N),
    .sb      (sb_if)
  );

  typedef struct {
    logic [IL-1:0] id;
    logic [SL-1:0] sc;
    bit            v;
    bit            chk;
  } rd_exp_t;

  int          n_tests = 0;
  int          n_fail  = 0;
  int unsigned cyc     = 0;

  // Reference model of board contents; wr_m marks entries with known payload.
  logic [IL-1:0] id_m  [ROWS][PE];
  logic [SL-1:0] sc_m  [ROWS][PE];
  bit            val_m [ROWS][PE];
  bit            wr_m  [ROWS][PE];

  bit          in_set    = 0;
  int unsigned set_start = 0;
  int unsigned busy_end  = 0;
  int unsigned done_q [$];
  rd_exp_t     rd_q [$];
  bit          rd_req  = 0;
  bit          rd_pend = 0;
  rd_exp_t     mx;
  int unsigned med;

  always @(posedge clk) cyc <= cyc + 1;
  always @(posedge clk) rd_pend <= rd_req;

  task automatic check(input string name, input longint unsigned act, input longint unsigned exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: compares DUT outputs with queued expectations away from the edge.
  always @(negedge clk) begin
    if (reset_N) begin
      check("busy", sb_if.busy, (in_set && cyc >= set_start && cyc < busy_end) ? 1 : 0);
      if (sb_if.done_score_board) begin
        if (done_q.size() == 0) check("unexpected_done", 1, 0);
        else begin
          med = done_q.pop_front();
          check("done_edge", cyc + 1, med);
        end
      end
      if (rd_pend) begin
        if (rd_q.size() == 0) check("rd_underflow", 1, 0);
        else begin
          mx = rd_q.pop_front();
          check("rd_valid", sb_if.rd_valid, mx.v);
          if (mx.chk) begin
            check("rd_id", sb_if.rd_id, mx.id);
            check("rd_score", sb_if.rd_score, mx.sc);
          end
        end
      end
    end
  end

  function automatic logic [PE*IL-1:0] rand_ids();
    logic [PE*IL-1:0] v;
    for (int i = 0; i < PE; i++) v[i*IL +: IL] = IL'($urandom);
    return v;
  endfunction

  function automatic logic [PE*SL-1:0] rand_scores();
    logic [PE*SL-1:0] v;
    for (int i = 0; i < PE; i++) v[i*SL +: SL] = SL'($urandom);
    return v;
  endfunction

  function automatic void model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < PE; p++) val_m[r][p] = 0;
  endfunction

  // Issue one start (optionally with clear); the model decides acceptance:
  // a set occupies the board for PE write cycles plus one done cycle.
  task automatic drive_start(input logic [FW-1:0] fr, input int row, input logic [IL-1:0] base,
                             input logic [PE*IL-1:0] ids, input logic [PE*SL-1:0] scs,
                             input logic [PE-1:0] vp, input bit clr);
    int unsigned e;
    sb_if.start_score_board = 1'b1;
    sb_if.clear_board       = clr;
    sb_if.frame_num         = fr;
    sb_if.row_sel_by_set    = RL'(row);
    sb_if.id_first_frame    = base;
    sb_if.id_in             = ids;
    sb_if.score_in          = scs;
    sb_if.valid_pe          = vp;
    @(posedge clk); #1;
    e = cyc;
    sb_if.start_score_board = 1'b0;
    sb_if.clear_board       = 1'b0;
    sb_if.frame_num         = FW'($urandom);
    sb_if.row_sel_by_set    = RL'($urandom);
    sb_if.id_first_frame    = IL'($urandom);
    sb_if.id_in             = rand_ids();
    sb_if.score_in          = rand_scores();
    sb_if.valid_pe          = PE'($urandom);
    if (!in_set || e > busy_end) begin
      if (clr) model_clear();
      for (int k = 0; k < PE; k++) begin
        if (fr == 0) begin
          id_m[row][k] = IL'((int'(base) + k) % (1 << IL));
          sc_m[row][k] = '0;
        end else begin
          id_m[row][k] = ids[k*IL +: IL];
          sc_m[row][k] = scs[k*SL +: SL];
        end
        val_m[row][k] = vp[k];
        wr_m[row][k]  = 1;
      end
      in_set    = 1;
      set_start = e;
      busy_end  = e + PE + 1;
      done_q.push_back(busy_end);
    end
  endtask

  task automatic clear_pulse();
    sb_if.clear_board = 1'b1;
    @(posedge clk); #1;
    if (!in_set || cyc > busy_end) model_clear();
    sb_if.clear_board = 1'b0;
  endtask

  task automatic wait_idle();
    for (int i = 0; i < 40 && sb_if.busy; i++) begin
      @(posedge clk); #1;
    end
    check("wait_idle_timeout", sb_if.busy, 0);
  endtask

  task automatic rd(input int row, input int pe, input logic [IL-1:0] id,
                    input logic [SL-1:0] sc, input bit v, input bit chk);
    rd_exp_t x;
    x.id = id; x.sc = sc; x.v = v; x.chk = chk;
    rd_q.push_back(x);
    sb_if.rd_row = RL'(row);
    sb_if.rd_pe  = PW'(pe);
    rd_req = 1;
    @(posedge clk); #1;
    rd_req = 0;
  endtask

  task automatic rd_model(input int row, input int pe);
    rd(row, pe, id_m[row][pe], sc_m[row][pe], val_m[row][pe], wr_m[row][pe]);
  endtask

  task automatic rd_row_all(input int row);
    for (int p = 0; p < PE; p++) rd_model(row, p);
  endtask

  task automatic rd_all();
    for (int r = 0; r < ROWS; r++) rd_row_all(r);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [PE*IL-1:0] ids;
    logic [PE*SL-1:0] scs;
    logic [IL-1:0]    old_id;
    logic [SL-1:0]    old_sc;
    bit               old_v;
    int               row;

    sb_if.start_score_board = 1'b0;
    sb_if.clear_board       = 1'b0;
    sb_if.frame_num         = '0;
    sb_if.row_sel_by_set    = '0;
    sb_if.id_first_frame    = '0;
    sb_if.id_in             = '0;
    sb_if.score_in          = '0;
    sb_if.valid_pe          = '0;
    sb_if.rd_row            = '0;
    sb_if.rd_pe             = '0;
    for (int r = 0; r < ROWS; r++)
      for (int p = 0; p < PE; p++) begin
        id_m[r][p] = '0; sc_m[r][p] = '0; val_m[r][p] = 0; wr_m[r][p] = 0;
      end

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", sb_if.busy, 0);
    check("rst_done", sb_if.done_score_board, 0);
    check("rst_rd_valid", sb_if.rd_valid, 0);
    check("rst_rd_id", sb_if.rd_id, 0);
    check("rst_rd_score", sb_if.rd_score, 0);
    reset_N = 1'b1;
    @(posedge clk); #1;

    // First frame into row 3; a second start three edges later must be ignored.
    drive_start(0, 3, 12'd17, rand_ids(), rand_scores(), 8'hFF, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    drive_start(7, 7, 12'd999, rand_ids(), rand_scores(), 8'hFF, 0);
    wait_idle();
    for (int p = 0; p < PE; p++) rd(3, p, IL'(17 + p), '0, 1, 1);
    rd_row_all(7);

    // Later frame into row 31 with a sparse valid mask.
    for (int i = 0; i < PE; i++) begin
      ids[i*IL +: IL] = IL'(100 + i);
      scs[i*SL +: SL] = SL'(10 * i);
    end
    drive_start(5, 31, 12'd0, ids, scs, 8'hA5, 0);
    wait_idle();
    rd(31, 1, 12'd101, 16'd10, 0, 1);
    rd(31, 2, 12'd102, 16'd20, 1, 1);
    rd_row_all(31);

    // Read-before-write on [3][2], which commits at the third edge after start.
    old_id = id_m[3][2]; old_sc = sc_m[3][2]; old_v = val_m[3][2];
    ids = rand_ids(); scs = rand_scores();
    drive_start(3, 3, 12'd0, ids, scs, 8'h00, 0);
    @(posedge clk); #1;
    @(posedge clk); #1;
    rd(3, 2, old_id, old_sc, old_v, 1);
    rd(3, 2, ids[2*IL +: IL], scs[2*SL +: SL], 0, 1);
    wait_idle();
    rd_row_all(3);

    // Clear while busy has no effect.
    drive_start(9, 10, 12'd0, rand_ids(), rand_scores(), 8'hFF, 0);
    @(posedge clk); #1;
    clear_pulse();
    wait_idle();
    rd_row_all(10);
    rd_row_all(31);

    // Reset in the middle of a write abandons the set without a done pulse.
    drive_start(2, 5, 12'd0, rand_ids(), rand_scores(), 8'hFF, 0);
    repeat (3) begin
      @(posedge clk); #1;
    end
    reset_N = 1'b0;
    in_set = 0;
    done_q.delete();
    model_clear();
    for (int p = 0; p < PE; p++) wr_m[5][p] = 0;
    #1;
    check("midrst_busy", sb_if.busy, 0);
    check("midrst_done", sb_if.done_score_board, 0);
    check("midrst_rd_valid", sb_if.rd_valid, 0);
    @(posedge clk); #1;
    reset_N = 1'b1;
    @(posedge clk); #1;
    rd_all();
    drive_start(0, 5, 12'd4090, rand_ids(), rand_scores(), 8'h3C, 0);
    wait_idle();
    rd_row_all(5);

    // Clear and start together: clear first, then row 0 is written.
    drive_start(6, 1, 12'd0, rand_ids(), rand_scores(), 8'hFF, 0);
    wait_idle();
    drive_start(1, 0, 12'd0, rand_ids(), rand_scores(), 8'hFF, 1);
    wait_idle();
    rd_all();

    // Random sets, idle clears and ignored starts during writes.
    for (int it = 0; it < 25; it++) begin
      row = int'($urandom_range(ROWS - 1));
      drive_start(($urandom_range(3) == 0) ? FW'(0) : FW'($urandom_range(65535, 1)), row,
                  IL'($urandom), rand_ids(), rand_scores(), PE'($urandom), $urandom_range(5) == 0);
      if ($urandom_range(1) == 1) begin
        repeat ($urandom_range(7)) begin
          @(posedge clk); #1;
        end
        drive_start(FW'($urandom), int'($urandom_range(ROWS - 1)), IL'($urandom),
                    rand_ids(), rand_scores(), PE'($urandom), 0);
      end
      wait_idle();
      if ($urandom_range(6) == 0) clear_pulse();
      rd_row_all(row);
      for (int j = 0; j < 4; j++)
        rd_model(int'($urandom_range(ROWS - 1)), int'($urandom_range(PE - 1)));
    end

    repeat (4) @(posedge clk);
    #1;
    check("done_q_drained", done_q.size(), 0);
    check("rd_q_drained", rd_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
